phase_freq_detector: RTL and testbench

Clocked tri-state phase-frequency detector for the PLL loop. Compares rising edges of the reference input `link` against the feedback `vco` and produces UP/DN correction pulses, their complements, and the two-bit `setting` word. The PLL top uses `setting[0]` as the pulse-active strobe and `setting[1]` as the correction direction. Instantiated once inside the PLL top, beside the pulse-length counter and the VCO model.

---
 rtl/phase_freq_detector_pkg.sv | 42 ++++
 rtl/phase_freq_detector_edge_sync.sv | 31 +++
 rtl/phase_freq_detector.sv | 101 ++++++++++
 tb/tb_phase_freq_detector.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/phase_freq_detector_pkg.sv
// Shared PLL definitions: PFD state encoding, direction codes for
// setting[1], default parameters and the PFD next-state rule.
package phase_freq_detector_pkg;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_MAX_PULSE   = 65535;
  localparam int DEF_CNT_W       = 16;

  // setting[1] encoding
  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DN   = 2'd2
  } pfd_state_e;

  // Tri-state PFD transition rule. A pulse always ends in IDLE (never
  // jumps UP<->DN), which guarantees one IDLE cycle between pulses.
  // The pulse limit wins over any edge arriving in the same cycle.
  function automatic pfd_state_e pfd_next(input pfd_state_e st,
                                          input logic       link_rise,
                                          input logic       vco_rise,
                                          input logic       at_limit);
    pfd_state_e nxt;
    nxt = ST_IDLE;
    case (st)
      ST_IDLE: begin
        if (link_rise && !vco_rise)      nxt = ST_UP;
        else if (vco_rise && !link_rise) nxt = ST_DN;
        else                             nxt = ST_IDLE;
      end
      // extra link edges while UP keep the pulse (frequency detection)
      ST_UP:   nxt = (at_limit || vco_rise)  ? ST_IDLE : ST_UP;
      ST_DN:   nxt = (at_limit || link_rise) ? ST_IDLE : ST_DN;
      default: nxt = ST_IDLE;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/phase_freq_detector_edge_sync.sv
// Multi-flop synchroniser for an asynchronous level followed by a
// single-cycle rising-edge detector on the synchronised level.
module edge_sync
  import phase_freq_detector_pkg::*;
#(
  parameter int STAGES = DEF_SYNC_STAGES
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_rise
);

  logic [STAGES-1:0] r_sync;
  logic              r_dly;

  // Shift the async level through the synchroniser chain, then delay once
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= '0;
      r_dly  <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
      r_dly  <= r_sync[STAGES-1];
    end
  end

  // A level held high yields exactly one rise; it must drop to re-arm
  assign o_rise = r_sync[STAGES-1] & ~r_dly;

endmodule

// File: rtl/phase_freq_detector.sv
// Clocked tri-state phase-frequency detector. Synchronises link and vco,
// detects their rising edges and produces registered UP/DN pulses, their
// complements and the setting word (strobe + direction).
module phase_freq_detector
  import phase_freq_detector_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int MAX_PULSE   = DEF_MAX_PULSE,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_link,
  input  logic       i_vco,
  output logic [1:0] o_setting,
  output logic       o_up,
  output logic       o_dn,
  output logic       o_upb,
  output logic       o_dnb
);

  // Last count value at which the pulse is still allowed to continue
  localparam logic [CNT_W-1:0] LIM = CNT_W'((MAX_PULSE == 0) ? 0 : MAX_PULSE - 1);
  localparam logic             LIMIT_ON = (MAX_PULSE != 0);

  logic             w_link_rise;
  logic             w_vco_rise;
  logic             w_at_limit;
  pfd_state_e       w_next;

  pfd_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_up;
  logic             r_dn;
  logic             r_upb;
  logic             r_dnb;
  logic [1:0]       r_setting;

  // Identical chains on both inputs keep the phase relation to +/-1 cycle
  edge_sync #(.STAGES(SYNC_STAGES)) u_sync_link (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_async (i_link),
    .o_rise  (w_link_rise)
  );

  edge_sync #(.STAGES(SYNC_STAGES)) u_sync_vco (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_async (i_vco),
    .o_rise  (w_vco_rise)
  );

  // r_cnt holds cycles already spent in the pulse minus one, so the
  // pulse is released after exactly MAX_PULSE high cycles
  assign w_at_limit = LIMIT_ON && (r_state != ST_IDLE) && (r_cnt >= LIM);
  assign w_next     = pfd_next(r_state, w_link_rise, w_vco_rise, w_at_limit);

  // State register and pulse-length counter (cleared on pulse entry)
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if ((r_state != ST_IDLE) && (w_next == r_state))
        r_cnt <= r_cnt + 1'b1;
      else
        r_cnt <= '0;
    end
  end

  // Outputs decoded from the next state so they line up with r_state
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_up      <= 1'b0;
      r_dn      <= 1'b0;
      r_upb     <= 1'b1;
      r_dnb     <= 1'b1;
      r_setting <= 2'b00;
    end else begin
      r_up         <= (w_next == ST_UP);
      r_dn         <= (w_next == ST_DN);
      r_upb        <= (w_next != ST_UP);
      r_dnb        <= (w_next != ST_DN);
      r_setting[0] <= (w_next != ST_IDLE);
      // direction loads on pulse entry and is held through IDLE
      if ((w_next == ST_UP) && (r_state != ST_UP))
        r_setting[1] <= DIR_UP;
      else if ((w_next == ST_DN) && (r_state != ST_DN))
        r_setting[1] <= DIR_DN;
    end
  end

  assign o_up      = r_up;
  assign o_dn      = r_dn;
  assign o_upb     = r_upb;
  assign o_dnb     = r_dnb;
  assign o_setting = r_setting;

endmodule

// File: tb/tb_phase_freq_detector.sv
// Bench for phase_freq_detector. Stimulus pushes the expected pulse
// (direction, width, first-high cycle) into a per-DUT queue; a monitor
// measures every pulse the DUT produces and compares against the queue.
// dut0 uses the default limit, dut1 uses MAX_PULSE=20.
module tb_phase_freq_detector;

  typedef struct {
    logic dir;
    int   width;
    int   start;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       link0 = 1'b0, vco0 = 1'b0, link1 = 1'b0, vco1 = 1'b0;
  logic [1:0] set0, set1;
  logic       up0, dn0, upb0, dnb0, up1, dn1, upb1, dnb1;

  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  logic mon_en = 1'b0;
  exp_t q0[$];
  exp_t q1[$];

  phase_freq_detector dut0 (
    .i_clk(clk), .i_rst(rst), .i_link(link0), .i_vco(vco0),
    .o_setting(set0), .o_up(up0), .o_dn(dn0), .o_upb(upb0), .o_dnb(dnb0)
  );

  phase_freq_detector #(.MAX_PULSE(20)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_link(link1), .i_vco(vco1),
    .o_setting(set1), .o_up(up1), .o_dn(dn1), .o_upb(upb1), .o_dnb(dnb1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Input driven now is sampled at the next edge and shows at edge +2 more
  task automatic push(input int inst, input logic dir, input int width);
    exp_t e;
    e.dir   = dir;
    e.width = width;
    e.start = cyc + 3;
    if (inst == 0) q0.push_back(e);
    else           q1.push_back(e);
  endtask

  // {up,dn,upb,dnb,setting} reset pattern = 0,0,1,1,00
  task automatic check_rst(input string nm, input int inst);
    if (inst == 0) check(nm, int'({up0, dn0, upb0, dnb0, set0}), 6'b001100);
    else           check(nm, int'({up1, dn1, upb1, dnb1, set1}), 6'b001100);
  endtask

  // Monitor: invariants every cycle, pulse measurement against scoreboard
  logic prev_act[2];
  int   pw[2];
  int   pst[2];
  logic pdir[2];

  always @(negedge clk) begin
    if (!mon_en) begin
      prev_act[0] = 1'b0;
      prev_act[1] = 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin : g_mon
        logic [1:0] s;
        logic       u, d, ub, db, have;
        exp_t       e;
        s  = (i == 0) ? set0 : set1;
        u  = (i == 0) ? up0  : up1;
        d  = (i == 0) ? dn0  : dn1;
        ub = (i == 0) ? upb0 : upb1;
        db = (i == 0) ? dnb0 : dnb1;
        check($sformatf("consistency%0d", i), int'({ub, db, s[0], u & d}),
              int'({~u, ~d, u | d, 1'b0}));
        if (s[0] && !prev_act[i]) begin
          pst[i]  = cyc;
          pw[i]   = 0;
          pdir[i] = s[1];
        end
        if (s[0]) begin
          pw[i]++;
          check($sformatf("dir_hold%0d", i), int'(s[1]), int'(pdir[i]));
        end
        if (!s[0] && prev_act[i]) begin
          have = 1'b1;
          e.dir = 1'b0; e.width = 0; e.start = 0;
          if (i == 0) begin
            if (q0.size() == 0) have = 1'b0; else e = q0.pop_front();
          end else begin
            if (q1.size() == 0) have = 1'b0; else e = q1.pop_front();
          end
          if (!have) begin
            check($sformatf("unexpected_pulse%0d_width", i), pw[i], 0);
          end else begin
            check($sformatf("pulse%0d_dir", i),   int'(pdir[i]), int'(e.dir));
            check($sformatf("pulse%0d_width", i), pw[i],         e.width);
            check($sformatf("pulse%0d_start", i), pst[i],        e.start);
            check($sformatf("pulse%0d_idle_dir", i), int'(s[1]), int'(e.dir));
          end
        end
        prev_act[i] = s[0];
      end
    end
  end

  initial begin
    // reset held 3 cycles with inputs toggling
    repeat (3) begin
      @(negedge clk);
      check_rst("rst_hold0", 0);
      check_rst("rst_hold1", 1);
      link0 = ~link0; vco0 = ~vco0; link1 = ~link1; vco1 = ~vco1;
    end
    rst = 1'b0;
    link0 = 1'b0; vco0 = 1'b0; link1 = 1'b0; vco1 = 1'b0;
    repeat (2) begin
      tick(1);
      check_rst("post_rst0", 0);
      check_rst("post_rst1", 1);
    end
    @(posedge clk) mon_en = 1'b1;

    // link leads vco by 10 cycles
    tick(2);
    link0 = 1'b1; push(0, 1'b0, 10);
    tick(3); link0 = 1'b0;
    tick(7); vco0 = 1'b1;
    tick(3); vco0 = 1'b0;
    tick(8);
    check("after_up_setting", int'(set0), 2'b00);

    // vco leads link by 7 cycles
    vco0 = 1'b1; push(0, 1'b1, 7);
    tick(3); vco0 = 1'b0;
    tick(4); link0 = 1'b1;
    tick(3); link0 = 1'b0;
    tick(8);
    check("after_dn_setting", int'(set0), 2'b10);

    // simultaneous rise: no pulse, direction untouched
    link0 = 1'b1; vco0 = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      if (k == 2) begin link0 = 1'b0; vco0 = 1'b0; end
      check("same_edge_setting", int'(set0), 2'b10);
    end

    // three link rises before vco: one continuous UP pulse
    link0 = 1'b1; push(0, 1'b0, 15);
    tick(2); link0 = 1'b0;
    tick(2); link0 = 1'b1;
    tick(2); link0 = 1'b0;
    tick(2); link0 = 1'b1;
    tick(2); link0 = 1'b0;
    tick(5); vco0 = 1'b1;
    tick(3); vco0 = 1'b0;
    tick(8);

    // MAX_PULSE=20, vco silent: limited pulse, then a fresh one
    link1 = 1'b1; push(1, 1'b0, 20);
    tick(3); link1 = 1'b0;
    tick(30);
    link1 = 1'b1; push(1, 1'b0, 20);
    tick(3); link1 = 1'b0;
    tick(30);
    // short pulse under the limit still ends on vco
    link1 = 1'b1; push(1, 1'b0, 5);
    tick(3); link1 = 1'b0;
    tick(2); vco1 = 1'b1;
    tick(3); vco1 = 1'b0;
    tick(8);

    // reset in the middle of an UP pulse
    @(posedge clk) mon_en = 1'b0;
    tick(1); link0 = 1'b1;
    tick(6);
    check("mid_pulse_up", int'(up0), 1);
    link0 = 1'b0; rst = 1'b1;
    tick(1);
    check_rst("mid_rst0", 0);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick(1);
      check_rst("no_resume0", 0);
    end
    @(posedge clk) mon_en = 1'b1;
    tick(5);

    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
